mux_nway_reg: RTL and testbench

//  Parametrised N-way, WIDTH-bit selector with a registered output stage and valid/ready handshake.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_nway_comb.sv | 24 ++
 rtl/mux_nway_reg.sv | 114 +++++++++++
 tb/tb_mux_nway_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults, state encoding and select-width helper for the N-way mux
package mux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 8;
    localparam int DEF_CNTW  = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_t;

    // A one-channel or two-channel mux still needs a 1-bit select port
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nway_comb.sv
// rtl/mux_nway_comb.sv - combinational N-way WIDTH-bit selector, zero word for out-of-range select
module mux_nway_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]    i_sel,
    output logic [WIDTH-1:0]   o_data
);

    // Equality match per channel: a select with no matching channel leaves the word at zero
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SELW'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_nway_reg.sv
// rtl/mux_nway_reg.sv - registered N-way selector with valid/ready handshake and accept counter (option: MUX_SEL_ERR_EN)
module mux_nway_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = sel_width(N),
    parameter int CNTW  = DEF_CNTW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNTW-1:0]    xfer_cnt,
    output logic               sel_err
);

    mux_state_t       r_state;
    mux_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_sel;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_accept;
    logic             w_consume;

    mux_nway_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_comb (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_sel_data)
    );

    // in_ready depends only on the output register and downstream, never on in_valid
    assign in_ready  = (r_state == ST_EMPTY) | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = (r_state == ST_FULL) & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_consume && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_sel  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_data <= w_sel_data;
            r_sel  <= in_sel;
            r_cnt  <= r_cnt + CNTW'(1);
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = (r_state == ST_FULL);
    assign xfer_cnt  = r_cnt;

`ifdef MUX_SEL_ERR_EN
    logic w_illegal;
    logic r_sel_err;

    // Only a non-power-of-two N leaves select codes without a channel
    if ((1 << SELW) > N) begin : g_sel_chk
        assign w_illegal = (in_sel >= SELW'(N));
    end else begin : g_sel_nochk
        assign w_illegal = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && w_accept && w_illegal) begin
            $error("mux_nway_reg: illegal select %0d accepted (N=%0d)", in_sel, N);
        end
    end
`endif
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nway_reg.sv
// tb/tb_mux_nway_reg.sv - self-checking bench: directed cases plus random handshake vs scoreboard
module tb_mux_nway_reg;

    localparam int W   = 32;
    localparam int NA  = 8;
    localparam int SA  = 3;
    localparam int CA  = 16;
    localparam int NB  = 6;
    localparam int SB  = 3;
    localparam int CB  = 4;
`ifdef MUX_SEL_ERR_EN
    localparam logic EXP_SERR = 1'b1;
`else
    localparam logic EXP_SERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_a, rst_b;
    logic [NA*W-1:0] a_in_data;
    logic [SA-1:0]   a_in_sel;
    logic            a_in_valid, a_in_ready;
    logic [W-1:0]    a_out_data;
    logic [SA-1:0]   a_out_sel;
    logic            a_out_valid, a_out_ready;
    logic [CA-1:0]   a_xfer_cnt;
    logic            a_sel_err;

    logic [NB*W-1:0] b_in_data;
    logic [SB-1:0]   b_in_sel;
    logic            b_in_valid, b_in_ready;
    logic [W-1:0]    b_out_data;
    logic [SB-1:0]   b_out_sel;
    logic            b_out_valid, b_out_ready;
    logic [CB-1:0]   b_xfer_cnt;
    logic            b_sel_err;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic [SA-1:0] s;
    } item_t;
    item_t sb_q[$];

    always #5 clk = ~clk;

    mux_nway_reg #(.WIDTH(W), .N(NA), .CNTW(CA)) u_dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .xfer_cnt  (a_xfer_cnt),
        .sel_err   (a_sel_err)
    );

    mux_nway_reg #(.WIDTH(W), .N(NB), .CNTW(CB)) u_dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .xfer_cnt  (b_xfer_cnt),
        .sel_err   (b_sel_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_d;
        int           acc_cnt;
        int           s;
        logic         cons, acc;

        rst_a = 1'b1; rst_b = 1'b1;
        a_in_valid = 1'b0; a_in_sel = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b0;
        for (int k = 0; k < NA; k++) a_in_data[k*W +: W] = 32'hA0 + k;
        for (int k = 0; k < NB; k++) b_in_data[k*W +: W] = 32'hA0 + k;
        #1;
        check_eq("rst_valid", a_out_valid, 0);
        check_eq("rst_data",  a_out_data, 0);
        check_eq("rst_sel",   a_out_sel, 0);
        check_eq("rst_cnt",   a_xfer_cnt, 0);
        check_eq("rst_serr",  a_sel_err, 0);
        check_eq("rst_ready", a_in_ready, 1);
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // back-to-back sweep of all eight channels
        a_out_ready = 1'b1;
        for (int k = 0; k < NA; k++) begin
            a_in_valid = 1'b1;
            a_in_sel   = SA'(k);
            #1;
            check_eq("sweep_ready", a_in_ready, 1);
            step();
            check_eq("sweep_data",  a_out_data, 32'hA0 + k);
            check_eq("sweep_sel",   a_out_sel, k);
            check_eq("sweep_valid", a_out_valid, 1);
        end
        a_in_valid = 1'b0;
        check_eq("sweep_cnt", a_xfer_cnt, 8);
        step();
        check_eq("drain_valid", a_out_valid, 0);

        // backpressure: hold 0xA3 while sel=5 is offered
        a_in_valid = 1'b1; a_in_sel = 3'd3;
        step();
        check_eq("bp_first", a_out_data, 32'hA3);
        a_out_ready = 1'b0; a_in_sel = 3'd5;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_ready", a_in_ready, 0);
            step();
            check_eq("bp_hold_data",  a_out_data, 32'hA3);
            check_eq("bp_hold_sel",   a_out_sel, 3);
            check_eq("bp_hold_valid", a_out_valid, 1);
        end
        a_out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", a_in_ready, 1);
        step();
        check_eq("bp_new_data", a_out_data, 32'hA5);
        check_eq("bp_new_sel",  a_out_sel, 5);
        a_in_valid = 1'b0;
        step();
        check_eq("consume_valid", a_out_valid, 0);
        check_eq("consume_keep",  a_out_data, 32'hA5);
        check_eq("bp_cnt",        a_xfer_cnt, 10);

        // reset while FULL and stalled
        a_in_valid = 1'b1; a_in_sel = 3'd2; a_out_ready = 1'b0;
        step();
        a_in_valid = 1'b0;
        check_eq("pre_rst_valid", a_out_valid, 1);
        check_eq("pre_rst_data",  a_out_data, 32'hA2);
        rst_a = 1'b1;
        #1;
        check_eq("midrst_valid", a_out_valid, 0);
        check_eq("midrst_data",  a_out_data, 0);
        check_eq("midrst_cnt",   a_xfer_cnt, 0);
        step();
        rst_a = 1'b0;

        // illegal select on the 6-way instance, then counter wrap at 4 bits
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_sel = 3'd7;
        step();
        check_eq("ill_data",  b_out_data, 0);
        check_eq("ill_valid", b_out_valid, 1);
        check_eq("ill_serr",  b_sel_err, EXP_SERR);
        b_in_sel = 3'd2;
        step();
        check_eq("legal_data", b_out_data, 32'hA2);
        check_eq("legal_serr", b_sel_err, EXP_SERR);
        for (int i = 0; i < 15; i++) begin
            s = $urandom_range(0, 7);
            b_in_sel = SB'(s);
            step();
            exp_d = (s < NB) ? 32'hA0 + s : 32'h0;
            check_eq("wrap_data", b_out_data, exp_d);
            check_eq("wrap_cnt",  b_xfer_cnt, (3 + i) % 16);
        end
        b_in_valid = 1'b0;
        check_eq("wrap_final", b_xfer_cnt, 1);
        check_eq("wrap_serr",  b_sel_err, EXP_SERR);

        // random traffic on the 8-way instance against a queue scoreboard
        acc_cnt = 0;
        sb_q.delete();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            check_eq("rnd_valid", a_out_valid, (sb_q.size() != 0) ? 1 : 0);
            check_eq("rnd_cnt",   a_xfer_cnt, acc_cnt % 65536);
            if (sb_q.size() != 0) begin
                check_eq("rnd_data", a_out_data, sb_q[0].d);
                check_eq("rnd_sel",  a_out_sel, sb_q[0].s);
            end
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_in_sel    = SA'($urandom_range(0, NA - 1));
            for (int k = 0; k < NA; k++) a_in_data[k*W +: W] = $urandom;
            #1;
            check_eq("rnd_ready", a_in_ready, (sb_q.size() == 0 || a_out_ready) ? 1 : 0);
            cons = (sb_q.size() != 0) && a_out_ready;
            acc  = a_in_valid && ((sb_q.size() == 0) || a_out_ready);
            if (cons) void'(sb_q.pop_front());
            if (acc) begin
                sb_q.push_back('{d: a_in_data[int'(a_in_sel)*W +: W], s: a_in_sel});
                acc_cnt++;
            end
        end
        @(negedge clk);
        check_eq("rnd_end_cnt", a_xfer_cnt, acc_cnt % 65536);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
